// File: rtl/msg_arb_pkg.sv
// Shared definitions for the message FIFO arbiter.
// Contents: FSM state enum, message length constant, word-index type,
// and the FIFO headroom helper used at grant time.
package msg_arb_pkg;

  localparam int MSG_WORDS = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    W_ID = 2'd1,
    W_1  = 2'd2,
    W_2  = 2'd3
  } arb_state_t;

  // Position of a word inside a message: 0 = ID, 1 = payload 1, 2 = payload 2.
  typedef logic [1:0] word_idx_t;

  // True when the FIFO can take a whole message. Both operands are zero-
  // extended to 32 bits, which gives the same unsigned result as comparing
  // at USEDW_W+1 bits.
  function automatic logic has_room(input logic [31:0] usedw,
                                    input logic [31:0] depth);
    return usedw < (depth - 32'(MSG_WORDS));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Searches the request vector starting one position after i_ptr (wrapping
// modulo N_REQ) and returns the first requester found.
// Ports:
//   i_req   requests, one bit per requester
//   i_ptr   index of the last winner
//   o_grant one-hot grant (all zero when nothing is requested)
//   o_idx   index of the winner
//   o_valid at least one request is pending
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  logic [IDX_W-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    // i runs 1..N_REQ so the last candidate checked is the previous winner.
    for (int i = 1; i <= N_REQ; i++) begin
      w_cand = IDX_W'((int'(i_ptr) + i) % N_REQ);
      if (!o_valid && i_req[w_cand]) begin
        o_valid         = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

endmodule

// File: rtl/msg_fifo_arbiter.sv
// Shares one CPU message FIFO between N_REQ producers. Each producer holds a
// level request with a 3-word message (ID, w1, w2); the arbiter grants
// round-robin when the FIFO has room for a full message, latches the
// winner's words and writes them on three consecutive cycles, then pulses
// that producer's ack on the last word.
//
// Optional build macro MSG_FIFO_ARBITER_SEQ_EN: an 8-bit sequence counter
// replaces ID bits [7:0] and advances on every ack (wraps, not cleared by
// flush). Undefined: ID words pass through unchanged.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   flush           FIFO flush pulse (also drives FIFO sclr); aborts a message
//   req             per-requester level request, held until ack
//   msg_id/w1/w2    per-requester message words
//   ack             one-hot pulse with the last word of a message
//   busy            a message is in flight
//   fifo_usedw      FIFO fill level
//   fifo_wrreq      FIFO write strobe
//   fifo_data       FIFO write data (zero when not writing)
//
// state | meaning
// IDLE  | waiting for a request with FIFO headroom
// W_ID  | writing the latched ID word
// W_1   | writing latched payload word 1
// W_2   | writing latched payload word 2, ack the winner
module msg_fifo_arbiter
  import msg_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int FIFO_DEPTH = 256,
  parameter int USEDW_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0][31:0] msg_id,
  input  logic [N_REQ-1:0][31:0] msg_w1,
  input  logic [N_REQ-1:0][31:0] msg_w2,
  output logic [N_REQ-1:0]      ack,
  output logic                  busy,
  input  logic [USEDW_W-1:0]    fifo_usedw,
  output logic                  fifo_wrreq,
  output logic [31:0]           fifo_data
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t       r_state;
  arb_state_t       w_next;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_prev_ptr;
  logic [N_REQ-1:0] r_win_oh;
  logic [31:0]      r_id;
  logic [31:0]      r_w1;
  logic [31:0]      r_w2;

  logic [N_REQ-1:0] w_grant;
  logic [IDX_W-1:0] w_win_idx;
  logic             w_any;
  logic             w_room;
  logic             w_start;
  logic [31:0]      w_id_out;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .i_req   (req),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_win_idx),
    .o_valid (w_any)
  );

  // Headroom is only looked at here; once granted the margin covers all
  // three words regardless of later usedw changes.
  assign w_room  = has_room(32'(fifo_usedw), 32'(FIFO_DEPTH));
  assign w_start = (r_state == IDLE) && w_any && w_room && !flush;

`ifdef MSG_FIFO_ARBITER_SEQ_EN
  logic [7:0] r_seq;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_seq <= 8'd0;
    end else if ((r_state == W_2) && !flush) begin
      r_seq <= r_seq + 8'd1;
    end
  end

  assign w_id_out = {r_id[31:8], r_seq};
`else
  assign w_id_out = r_id;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rr_ptr   <= IDX_W'(N_REQ - 1);
      r_prev_ptr <= IDX_W'(N_REQ - 1);
      r_win_oh   <= '0;
      r_id       <= '0;
      r_w1       <= '0;
      r_w2       <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_prev_ptr <= r_rr_ptr;
        r_rr_ptr   <= w_win_idx;
        r_win_oh   <= w_grant;
        r_id       <= msg_id[w_win_idx];
        r_w1       <= msg_w1[w_win_idx];
        r_w2       <= msg_w2[w_win_idx];
      end else if (flush && (r_state != IDLE)) begin
        // Aborted message: the same requester gets first chance again.
        r_rr_ptr <= r_prev_ptr;
      end
    end
  end

  // Outputs are decoded from the state and latched-word registers. The flush
  // pulse also clears the FIFO this cycle, so the word in flight is masked
  // rather than written into a FIFO that is being emptied, and no ack is
  // given for a message that did not complete.
  always_comb begin
    w_next     = r_state;
    fifo_wrreq = 1'b0;
    fifo_data  = '0;
    ack        = '0;
    case (r_state)
      IDLE: begin
        if (w_start) w_next = W_ID;
      end
      W_ID: begin
        w_next = flush ? IDLE : W_1;
        if (!flush) begin
          fifo_wrreq = 1'b1;
          fifo_data  = w_id_out;
        end
      end
      W_1: begin
        w_next = flush ? IDLE : W_2;
        if (!flush) begin
          fifo_wrreq = 1'b1;
          fifo_data  = r_w1;
        end
      end
      W_2: begin
        w_next = IDLE;
        if (!flush) begin
          fifo_wrreq = 1'b1;
          fifo_data  = r_w2;
          ack        = r_win_oh;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_msg_fifo_arbiter.sv
module tb_msg_fifo_arbiter;

  localparam int N_REQ = 4;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   flush = 1'b0;
  logic [N_REQ-1:0]       req = '0;
  logic [N_REQ-1:0][31:0] tb_id = '0;
  logic [N_REQ-1:0][31:0] tb_w1 = '0;
  logic [N_REQ-1:0][31:0] tb_w2 = '0;
  logic [N_REQ-1:0]       ack;
  logic                   busy;
  logic [7:0]             usedw = 8'd0;
  logic                   wrreq;
  logic [31:0]            data;

  msg_fifo_arbiter #(
    .N_REQ      (N_REQ),
    .FIFO_DEPTH (256),
    .USEDW_W    (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .req        (req),
    .msg_id     (tb_id),
    .msg_w1     (tb_w1),
    .msg_w2     (tb_w2),
    .ack        (ack),
    .busy       (busy),
    .fifo_usedw (usedw),
    .fifo_wrreq (wrreq),
    .fifo_data  (data)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_acks  = 0;
  logic [31:0] wq[$];
  logic [3:0]  aq[$];
  int          ack_cyc[$];
  logic [7:0]  exp_seq = 8'd0;

  typedef struct {
    logic [3:0] req;
    int         win;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] exp_id_word(input logic [31:0] id);
`ifdef MSG_FIFO_ARBITER_SEQ_EN
    return {id[31:8], exp_seq};
`else
    return id;
`endif
  endfunction

  task automatic push_msg(input int who);
    logic [3:0] m;
    m = 4'b0001 << who;
    wq.push_back(exp_id_word(tb_id[who]));
    wq.push_back(tb_w1[who]);
    wq.push_back(tb_w2[who]);
    aq.push_back(m);
    exp_seq = exp_seq + 8'd1;
  endtask

  task automatic set_payload(input int v);
    for (int k = 0; k < N_REQ; k++) begin
      tb_id[k] = {8'hA0, 8'(v), 8'(k), 8'h3C};
      tb_w1[k] = {8'hB1, 8'(v), 8'(k), 8'h5A};
      tb_w2[k] = {8'hC2, 8'(k), 8'(v), 8'h96};
    end
  endtask

  task automatic wait_acks(input int target, input int budget, input string name);
    int i;
    i = 0;
    while (n_acks < target && i < budget) begin
      tick();
      i++;
    end
    check(name, 32'(n_acks), 32'(target));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    flush = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_wrreq", 32'(wrreq), 32'h0);
    check("rst_data", data, 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    reset   = 1'b0;
    exp_seq = 8'd0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    int base;
    int n_seq_msgs;

    // Round-robin expectations, pointer starts at 0 after the first message.
    vecs[0] = '{4'b0011, 1};
    vecs[1] = '{4'b0011, 0};
    vecs[2] = '{4'b1100, 2};
    vecs[3] = '{4'b1111, 3};
    vecs[4] = '{4'b1010, 1};
    vecs[5] = '{4'b0100, 2};
    vecs[6] = '{4'b1001, 3};
    vecs[7] = '{4'b0110, 1};

    fork
      forever begin
        @(negedge clk);
        cyc++;
        if (!reset) begin
          if (wrreq) begin
            if (wq.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL unexpected_write: got data %h, no write expected", data);
            end else begin
              check("fifo_data", data, wq.pop_front());
            end
          end else begin
            check("idle_data_zero", data, 32'h0);
          end
          if (ack != '0) begin
            n_acks++;
            ack_cyc.push_back(cyc);
            check("ack_with_write", 32'(wrreq), 32'h1);
            if (aq.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL unexpected_ack: got %b, no ack expected", ack);
            end else begin
              check("ack", 32'(ack), 32'(aq.pop_front()));
            end
          end
        end
      end
    join_none

    do_reset();

    // Single request with the reference message.
    tb_id[0] = 32'h0052_4242;
    tb_w1[0] = 32'h0010_0200;
    tb_w2[0] = 32'h0;
    req = 4'b0001;
    c0 = cyc;
    push_msg(0);
    wait_acks(n_acks + 1, 20, "single_ack_seen");
    check("single_latency", 32'(ack_cyc[ack_cyc.size()-1] - c0), 32'd4);
    req = '0;
    tick();

    // Table of request patterns with hand-derived round-robin winners.
    for (int v = 0; v < 8; v++) begin
      set_payload(v + 1);
      req = vecs[v].req;
      c0 = cyc;
      push_msg(vecs[v].win);
      wait_acks(n_acks + 1, 20, "vec_ack_seen");
      check("vec_latency", 32'(ack_cyc[ack_cyc.size()-1] - c0), 32'd4);
      req = '0;
      tick();
    end

    // Headroom boundary: 253 blocks, 252 grants on the next cycle.
    set_payload(20);
    usedw = 8'd253;
    req = 4'b0010;
    base = n_acks;
    for (int i = 0; i < 6; i++) tick();
    check("full_no_grant_busy", 32'(busy), 32'h0);
    check("full_no_ack", 32'(n_acks), 32'(base));
    usedw = 8'd252;
    push_msg(1);
    tick();
    check("room_grant_busy", 32'(busy), 32'h1);
    check("room_grant_wrreq", 32'(wrreq), 32'h1);
    usedw = 8'd255;
    wait_acks(n_acks + 1, 20, "room_ack_seen");
    usedw = 8'd0;
    req = '0;
    tick();

    // Flush in W_1 aborts requester 2, which is then regranted first.
    set_payload(30);
    req = 4'b1111;
    base = n_acks;
    wq.push_back(exp_id_word(tb_id[2]));
    tick();
    tick();
    check("flush_in_w1_busy", 32'(busy), 32'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_abort_idle", 32'(busy), 32'h0);
    check("flush_no_ack", 32'(n_acks), 32'(base));
    push_msg(2);
    wait_acks(n_acks + 1, 20, "flush_retry_ack_seen");
    req = '0;
    tick();

    // Flush in IDLE blocks grant; then payload is latched at grant.
    set_payload(40);
    req = 4'b0001;
    flush = 1'b1;
    tick();
    check("flush_idle_no_grant", 32'(busy), 32'h0);
    tick();
    check("flush_idle_no_grant2", 32'(busy), 32'h0);
    flush = 1'b0;
    push_msg(0);
    tick();
    check("latch_busy", 32'(busy), 32'h1);
    req = '0;
    tb_id[0] = 32'hDEAD_0001;
    tb_w1[0] = 32'hDEAD_0002;
    tb_w2[0] = 32'hDEAD_0003;
    wait_acks(n_acks + 1, 20, "latch_ack_seen");
    tick();

    // All requesters held: order 0,1,2,3,0 from reset, acks 4 cycles apart.
    do_reset();
    set_payload(50);
    req = 4'b1111;
    base = ack_cyc.size();
    push_msg(0);
    push_msg(1);
    push_msg(2);
    push_msg(3);
    push_msg(0);
    wait_acks(n_acks + 5, 40, "rr_all_acks_seen");
    req = '0;
    for (int k = 0; k < 4; k++) begin
      check("rr_ack_spacing", 32'(ack_cyc[base+k+1] - ack_cyc[base+k]), 32'd4);
    end
    tick();

    // Sequence numbering (or pass-through ID when the counter is absent).
    do_reset();
`ifdef MSG_FIFO_ARBITER_SEQ_EN
    n_seq_msgs = 257;
`else
    n_seq_msgs = 8;
`endif
    for (int m = 0; m < n_seq_msgs; m++) begin
      for (int k = 0; k < N_REQ; k++) begin
        tb_id[k] = {8'hC0, 8'(m), 8'(k), 8'hC3};
        tb_w1[k] = {8'hD0, 8'(m), 8'(k), 8'h01};
        tb_w2[k] = {8'hE0, 8'(m), 8'(k), 8'h02};
      end
      req = 4'b0001 << (m % N_REQ);
      push_msg(m % N_REQ);
      wait_acks(n_acks + 1, 20, "seq_ack_seen");
      req = '0;
      tick();
    end

    tick();
    tick();
    check("words_all_seen", 32'(wq.size()), 32'd0);
    check("acks_all_seen", 32'(aq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
